// File: rtl/gpu_prefetch_queue.sv
// gpu_prefetch_queue: instruction prefetch queue for the GPU/DSP RISC core.
// Fetches 32-bit longwords over progreq/progack, splits them big-endian into
// 16-bit words and hands them with their PC to the decoder over ins_ready/ins_take.
// Ports: sys_clk, reset (sync, active-high), go, pc_load, pc_new,
//        progaddr, progreq, progack, prog_data,
//        ins_ready, ins_word, ins_pc, ins_take, pabort, level.
// Optional macro PREFETCH_STATS_EN adds fetch_count and abort_count outputs.
module gpu_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 22,
  parameter bit JERRY = 1'b0
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          go,
  input  logic                          pc_load,
  input  logic [ADDR_W-1:0]             pc_new,
  output logic [ADDR_W-1:0]             progaddr,
  output logic                          progreq,
  input  logic                          progack,
  input  logic [31:0]                   prog_data,
  output logic                          ins_ready,
  output logic [15:0]                   ins_word,
  output logic [ADDR_W-1:0]             ins_pc,
  input  logic                          ins_take,
  output logic                          pabort,
  output logic [$clog2(2*DEPTH):0]      level
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]                   fetch_count,
  output logic [7:0]                    abort_count
`endif
);
  localparam int N = 2 * DEPTH;
  localparam int PW = $clog2(N);
  localparam int LW = PW + 1;
  localparam logic [ADDR_W-1:0] RST_ADDR = JERRY ? ADDR_W'(32'hF1B000) : ADDR_W'(32'hF03000);
  logic [15:0] mem_q [N];
  logic [15:0] mem_d [N];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] level_q, level_d, push_n;
  logic [ADDR_W-1:0] addr_q, addr_d, pc_q, pc_d;
  logic req_q, req_d, abort_q, abort_d, skip_q, skip_d;
  logic accept, pop;
  assign accept = req_q & progack & ~pc_load;
  assign pop = ins_ready & ins_take & ~pc_load;
  // an odd-halfword jump target drops the high half of the first longword
  assign push_n = accept ? (skip_q ? LW'(1) : LW'(2)) : '0;
  always_comb begin
    mem_d = mem_q;
    if (accept && skip_q) mem_d[wr_q] = prog_data[15:0];
    else if (accept) begin
      mem_d[wr_q] = prog_data[31:16];
      mem_d[wr_q + PW'(1)] = prog_data[15:0];
    end
    rd_d = pc_load ? '0 : rd_q + PW'(pop);
    wr_d = pc_load ? '0 : wr_q + push_n[PW-1:0];
    level_d = pc_load ? '0 : level_q + push_n - LW'(pop);
    addr_d = pc_load ? (pc_new & ~ADDR_W'(3)) : accept ? addr_q + ADDR_W'(4) : addr_q;
    pc_d = pc_load ? (pc_new & ~ADDR_W'(1)) : pop ? pc_q + ADDR_W'(2) : pc_q;
    skip_d = pc_load ? pc_new[1] : accept ? 1'b0 : skip_q;
    // space check uses registered level, so a same-cycle pop never enables a request
    req_d = (pc_load || accept) ? 1'b0 : (req_q | (go & (level_q <= LW'(N - 2))));
    abort_d = pc_load & req_q & ~progack;
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
      addr_q <= RST_ADDR;
      pc_q <= RST_ADDR;
      skip_q <= 1'b0;
      req_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      level_q <= level_d;
      addr_q <= addr_d;
      pc_q <= pc_d;
      skip_q <= skip_d;
      req_q <= req_d;
      abort_q <= abort_d;
    end
  end
  assign progaddr = addr_q;
  assign progreq = req_q;
  assign pabort = abort_q;
  assign level = level_q;
  assign ins_ready = |level_q;
  assign ins_pc = pc_q;
  assign ins_word = ins_ready ? mem_q[rd_q] : '0;
`ifdef PREFETCH_STATS_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [7:0] abort_count_q, abort_count_d;
  always_comb begin
    fetch_count_d = fetch_count_q + 16'(accept & ~&fetch_count_q);
    abort_count_d = abort_count_q + 8'(abort_d & ~&abort_count_q);
  end
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      abort_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      abort_count_q <= abort_count_d;
    end
  end
  assign fetch_count = fetch_count_q;
  assign abort_count = abort_count_q;
`endif
endmodule
